// File: rtl/ahb3lite_host_slave.sv
// AHB3-lite slave that serialises each transfer into a host request frame on the TX byte FIFO
// and completes the data phase from the host's response frame. Optional: HOST_SLAVE_TIMEOUT_EN.
module ahb3lite_host_slave #(
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        WREN,
  input  logic        WRFULL,
  output logic [7:0]  WRDATA,
  output logic        RDEN,
  input  logic        RDEMPTY,
  input  logic [7:0]  RDDATA,
  output logic [3:0]  fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TX_CMD  = 4'd1,
    S_TX_ADDR = 4'd2,
    S_TX_DATA = 4'd3,
    S_RX_STAT = 4'd4,
    S_RX_DATA = 4'd5,
    S_DONE    = 4'd6,
    S_ERR1    = 4'd7,
    S_ERR2    = 4'd8
  } state_t;

  state_t      state, state_next;
  logic [1:0]  idx_q, idx_next;
  logic        rd_pend_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic        accept;

  assign fsm_state = state;

  // A new address phase is taken only when the previous transfer is fully finished (IDLE)
  // or is completing OKAY this cycle (DONE); ERR2 deliberately refuses pipelined accepts.
  assign accept = HSEL & HREADY & HTRANS[1] & ((state == S_IDLE) | (state == S_DONE));

  logic unused_bits;
  assign unused_bits = ^{HBURST, HPROT, HTRANS[0]};

`ifdef HOST_SLAVE_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        timeout_hit;

  assign timeout_hit = (state == S_RX_STAT) & ~rd_pend_q & RDEMPTY &
                       (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wait_cnt_q <= 32'd0;
    end else if (state != S_RX_STAT) begin
      wait_cnt_q <= 32'd0;
    end else if (!rd_pend_q && RDEMPTY) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // FIFO handshake: WREN pushes WRDATA only in a cycle where WRFULL=0. RDEN pops only when
  // RDEMPTY=0, RDDATA is taken the following cycle, and no new RDEN issues in that cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    WREN       = 1'b0;
    WRDATA     = 8'h00;
    RDEN       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_TX_CMD;
      end
      S_TX_CMD: begin
        HREADYOUT = 1'b0;
        WRDATA    = {write_q, size_q, 4'h0};
        if (!WRFULL) begin
          WREN       = 1'b1;
          idx_next   = 2'd3;
          state_next = S_TX_ADDR;
        end
      end
      S_TX_ADDR: begin
        HREADYOUT = 1'b0;
        WRDATA    = addr_q[{idx_q, 3'b000} +: 8];
        if (!WRFULL) begin
          WREN = 1'b1;
          if (idx_q == 2'd0) begin
            idx_next   = 2'd3;
            state_next = write_q ? S_TX_DATA : S_RX_STAT;
          end else begin
            idx_next = idx_q - 2'd1;
          end
        end
      end
      S_TX_DATA: begin
        HREADYOUT = 1'b0;
        WRDATA    = wdata_q[{idx_q, 3'b000} +: 8];
        if (!WRFULL) begin
          WREN = 1'b1;
          if (idx_q == 2'd0) begin
            state_next = S_RX_STAT;
          end else begin
            idx_next = idx_q - 2'd1;
          end
        end
      end
      S_RX_STAT: begin
        HREADYOUT = 1'b0;
        if (rd_pend_q) begin
          if (RDDATA != 8'h00) begin
            state_next = S_ERR1;
          end else if (write_q) begin
            state_next = S_DONE;
          end else begin
            idx_next   = 2'd3;
            state_next = S_RX_DATA;
          end
        end else if (!RDEMPTY) begin
          RDEN = 1'b1;
        end
`ifdef HOST_SLAVE_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = S_ERR1;
        end
`endif
      end
      S_RX_DATA: begin
        HREADYOUT = 1'b0;
        if (rd_pend_q) begin
          if (idx_q == 2'd0) begin
            state_next = S_DONE;
          end else begin
            idx_next = idx_q - 2'd1;
          end
        end else if (!RDEMPTY) begin
          RDEN = 1'b1;
        end
      end
      S_DONE: begin
        state_next = accept ? S_TX_CMD : S_IDLE;
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      idx_q     <= 2'd0;
      rd_pend_q <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      HRDATA    <= 32'd0;
    end else begin
      state     <= state_next;
      idx_q     <= idx_next;
      rd_pend_q <= RDEN;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
      // HWDATA is stable across the whole first data-phase cycle, including WRFULL stalls.
      if (state == S_TX_CMD) wdata_q <= HWDATA;
      // Response data arrives MSB first, so shifting left assembles the word in place.
      if (state == S_RX_DATA && rd_pend_q) HRDATA <= {HRDATA[23:0], RDDATA};
      if (state == S_ERR1) HRDATA <= ERR_RDATA;
    end
  end

endmodule

// File: tb/tb_ahb3lite_host_slave.sv
// Bench for ahb3lite_host_slave: table vectors, hand sequences and random transfers checked
// against a frame-level reference model with modelled TX/RX byte FIFOs.
module tb_ahb3lite_host_slave;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam int TMO = 16;

  logic        CLK, RESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT, fsm_state;
  logic [1:0]  HTRANS;
  logic        WREN, WRFULL, RDEN, RDEMPTY;
  logic [7:0]  WRDATA, RDDATA;

  ahb3lite_host_slave #(.ERR_RDATA(ERR_RDATA), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .WREN(WREN), .WRFULL(WRFULL), .WRDATA(WRDATA), .RDEN(RDEN), .RDEMPTY(RDEMPTY),
    .RDDATA(RDDATA), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- vectors and model ----------------
  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  status;
    logic [31:0] rdata;
    int          stall_at;
    int          stall_len;
    int          rx_at;
    int          exp_len;
    logic [71:0] exp_tx;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    int          exp_pops;
  } vec_t;

  int          n_checks, n_errors;
  logic [7:0]  tx_log[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  pend_q[$];
  logic [7:0]  exp_q[$];
  int          pops, xcyc, stall_at, stall_len, rx_at;
  logic        prev_rden;

  function automatic vec_t mkv(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input logic [7:0] st, input logic [31:0] rd,
                               input int s_at, input int s_len, input int r_at, input int e_len,
                               input logic [71:0] e_tx, input logic e_resp,
                               input logic [31:0] e_rd, input int e_pops);
    vec_t v;
    v.write = wr; v.size = sz; v.addr = a; v.wdata = wd; v.status = st; v.rdata = rd;
    v.stall_at = s_at; v.stall_len = s_len; v.rx_at = r_at; v.exp_len = e_len;
    v.exp_tx = e_tx; v.exp_resp = e_resp; v.exp_rdata = e_rd; v.exp_pops = e_pops;
    return v;
  endfunction

  // Frame-level reference: what the host must see and what the bus must get back.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_tx = {v.write, v.size, 4'h0, v.addr, (v.write ? v.wdata : 32'h0)};
    r.exp_len = v.write ? 9 : 5;
    r.exp_resp = (v.status != 8'h00);
    r.exp_rdata = r.exp_resp ? ERR_RDATA : v.rdata;
    r.exp_pops = (r.exp_resp || v.write) ? 1 : 5;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name);
    check($sformatf("%s_tx_len", name), 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_log.size())
        check($sformatf("%s_tx_byte%0d", name, i), 32'(tx_log[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- drivers ----------------
  // One clock: observe the FIFO-side strobes that the coming edge will take, then update
  // the modelled FIFOs and stall/arrival controls just after the edge.
  task automatic tick();
    logic pop_now;
    @(negedge CLK);
    pop_now = RDEN;
    if (WREN) tx_log.push_back(WRDATA);
    if (WRFULL) check("wren_while_full", 32'(WREN), 32'd0);
    if (RDEN) begin
      check("rden_while_empty", 32'(RDEMPTY), 32'd0);
      check("rden_outstanding", 32'(prev_rden), 32'd0);
    end
    prev_rden = RDEN;
    @(posedge CLK);
    #1;
    xcyc++;
    if (pop_now && rx_q.size() > 0) begin
      RDDATA = rx_q.pop_front();
      pops++;
    end
    if (xcyc >= rx_at) while (pend_q.size() > 0) rx_q.push_back(pend_q.pop_front());
    RDEMPTY = (rx_q.size() == 0);
    WRFULL = (stall_len > 0) && (xcyc >= stall_at) && (xcyc < stall_at + stall_len);
  endtask

  task automatic clear_env();
    tx_log.delete(); rx_q.delete(); pend_q.delete(); exp_q.delete();
    pops = 0; stall_at = 0; stall_len = 0; rx_at = 0;
    WRFULL = 1'b0; RDEMPTY = 1'b1;
  endtask

  task automatic start(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HWRITE = wr; HSIZE = sz; HADDR = a;
    HBURST = 3'($urandom_range(0, 7)); HPROT = 4'($urandom_range(0, 15));
    xcyc = 0;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1));
    HWDATA = wd;
  endtask

  task automatic wait_done(output int waits, output logic resp, output logic [31:0] rd,
                           output int resp_low);
    waits = 0;
    resp_low = 0;
    while (HREADYOUT !== 1'b1 && waits < 3000) begin
      waits++;
      if (HRESP === 1'b1) resp_low++;
      tick();
    end
    check("done_within_budget", 32'(waits < 3000), 32'd1);
    resp = HRESP;
    rd = HRDATA;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int waits, resp_low;
    logic resp;
    logic [31:0] rd;
    clear_env();
    pend_q.push_back(v.status);
    if (!(v.write && v.status == 8'h00))
      for (int i = 3; i >= 0; i--) pend_q.push_back(v.rdata[8*i +: 8]);
    stall_at = v.stall_at; stall_len = v.stall_len; rx_at = v.rx_at;
    if (rx_at == 0) while (pend_q.size() > 0) rx_q.push_back(pend_q.pop_front());
    RDEMPTY = (rx_q.size() == 0);
    start(v.write, v.size, v.addr, v.wdata);
    wait_done(waits, resp, rd, resp_low);
    check($sformatf("%s_hresp", tag), 32'(resp), 32'(v.exp_resp));
    check($sformatf("%s_err1_cycles", tag), 32'(resp_low), v.exp_resp ? 32'd1 : 32'd0);
    if (!v.write || v.exp_resp) check($sformatf("%s_hrdata", tag), rd, v.exp_rdata);
    if (!v.write && !v.exp_resp && v.stall_len == 0 && v.rx_at <= 1)
      check($sformatf("%s_min_latency", tag), 32'(waits >= 15), 32'd1);
    tick();
    check($sformatf("%s_idle_ready", tag), 32'(HREADYOUT), 32'd1);
    check($sformatf("%s_idle_resp", tag), 32'(HRESP), 32'd0);
    check($sformatf("%s_rx_pops", tag), 32'(pops), 32'(v.exp_pops));
    for (int i = 0; i < v.exp_len; i++) exp_q.push_back(v.exp_tx[71 - 8*i -: 8]);
    check_frame(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_hreadyout", tag), 32'(HREADYOUT), 32'd1);
    check($sformatf("%s_hresp", tag), 32'(HRESP), 32'd0);
    check($sformatf("%s_hrdata", tag), HRDATA, 32'd0);
    check($sformatf("%s_wren", tag), 32'(WREN), 32'd0);
    check($sformatf("%s_rden", tag), 32'(RDEN), 32'd0);
    check($sformatf("%s_wrdata", tag), 32'(WRDATA), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t        tbl[7];
  vec_t        v;
  int          waits, resp_low;
  logic        resp;
  logic [31:0] rd;
  logic [79:0] b2b_reply;

  initial begin
    n_checks = 0; n_errors = 0; prev_rden = 1'b0; xcyc = 0;
    HSEL = 1'b0; HADDR = 32'd0; HWDATA = 32'd0; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'b00; HREADY = 1'b1; RDDATA = 8'h00;
    clear_env();

    tbl[0] = mkv(1'b0, 3'd2, 32'h4000_0010, 32'h0, 8'h00, 32'h1234_5678, 0, 0, 0,
                 5, 72'h20_4000_0010_0000_0000, 1'b0, 32'h1234_5678, 5);
    tbl[1] = mkv(1'b1, 3'd0, 32'h4000_0004, 32'hCAFE_F00D, 8'h00, 32'h0, 0, 0, 0,
                 9, 72'h80_4000_0004_CAFE_F00D, 1'b0, 32'h0, 1);
    tbl[2] = mkv(1'b0, 3'd2, 32'h4000_0020, 32'h0, 8'h01, 32'h1122_3344, 0, 0, 0,
                 5, 72'h20_4000_0020_0000_0000, 1'b1, 32'hDEAD_BEEF, 1);
    tbl[3] = mkv(1'b0, 3'd1, 32'h4000_0008, 32'h0, 8'h00, 32'hA5A5_5A5A, 3, 20, 0,
                 5, 72'h10_4000_0008_0000_0000, 1'b0, 32'hA5A5_5A5A, 5);
    tbl[4] = mkv(1'b1, 3'd2, 32'h1234_5678, 32'h0BAD_F00D, 8'h7F, 32'h5555_AAAA, 0, 0, 0,
                 9, 72'hA0_1234_5678_0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 1);
    tbl[5] = mkv(1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 8'h00, 32'h89AB_CDEF, 0, 0, 20,
                 5, 72'h20_FFFF_FFFC_0000_0000, 1'b0, 32'h89AB_CDEF, 5);
    tbl[6] = mkv(1'b1, 3'd1, 32'h0000_0100, 32'h0102_0304, 8'h00, 32'h0, 1, 5, 0,
                 9, 72'h90_0000_0100_0102_0304, 1'b0, 32'h0, 1);

    // reset state
    RESETn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    RESETn = 1'b1;
    tick();

    // IDLE / BUSY / unselected / HREADY-low address phases complete with zero waits
    clear_env();
    HSEL = 1'b1; HTRANS = 2'b00; tick();
    check("idle_xfer_ready", 32'(HREADYOUT), 32'd1);
    check("idle_xfer_resp", 32'(HRESP), 32'd0);
    HTRANS = 2'b01; tick();
    check("busy_xfer_ready", 32'(HREADYOUT), 32'd1);
    HSEL = 1'b0; HTRANS = 2'b10; tick();
    check("unselected_ready", 32'(HREADYOUT), 32'd1);
    HSEL = 1'b1; HREADY = 1'b0; tick();
    check("hready_low_ready", 32'(HREADYOUT), 32'd1);
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; tick();
    check("idle_no_tx", 32'(tx_log.size()), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // back-to-back reads: second address phase lands in the DONE cycle
    clear_env();
    b2b_reply = 80'h00_AABB_CCDD_00_0102_0304;
    for (int i = 0; i < 10; i++) rx_q.push_back(b2b_reply[79 - 8*i -: 8]);
    RDEMPTY = 1'b0;
    start(1'b0, 3'd2, 32'h4000_0100, 32'h0);
    wait_done(waits, resp, rd, resp_low);
    check("b2b_first_rdata", rd, 32'hAABB_CCDD);
    check("b2b_first_resp", 32'(resp), 32'd0);
    start(1'b0, 3'd2, 32'h4000_0104, 32'h0);
    check("b2b_wait_next", 32'(HREADYOUT), 32'd0);
    tick();
    check("b2b_cmd_next", 32'(tx_log.size()), 32'd6);
    wait_done(waits, resp, rd, resp_low);
    check("b2b_second_rdata", rd, 32'h0102_0304);
    tick();
    check("b2b_pops", 32'(pops), 32'd10);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h20); exp_q.push_back(8'h40); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back(i == 0 ? 8'h00 : 8'h04);
    end
    check_frame("b2b");

    // address phase during ERR2 is not accepted
    clear_env();
    rx_q.push_back(8'h05);
    for (int i = 0; i < 4; i++) rx_q.push_back(8'hEE);
    RDEMPTY = 1'b0;
    start(1'b0, 3'd2, 32'h4000_0030, 32'h0);
    wait_done(waits, resp, rd, resp_low);
    check("err2_resp", 32'(resp), 32'd1);
    check("err2_rdata", rd, ERR_RDATA);
    start(1'b0, 3'd2, 32'h4000_0034, 32'h0);
    check("err2_ignore_ready", 32'(HREADYOUT), 32'd1);
    tick();
    check("err2_ignore_tx", 32'(tx_log.size()), 32'd5);
    check("err2_pops", 32'(pops), 32'd1);

    // randomized transfers against the frame model
    for (int n = 0; n < 40; n++) begin
      v = '0;
      v.write = 1'($urandom_range(0, 1));
      v.size = 3'($urandom_range(0, 2));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.status = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 3) == 0) begin
        v.stall_at = $urandom_range(1, 8);
        v.stall_len = $urandom_range(1, 10);
      end
      v.rx_at = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 20);
      v = model(v);
      run_vec(v, $sformatf("rand%0d", n));
    end

    // reset in the middle of a write frame
    clear_env();
    start(1'b1, 3'd2, 32'h5555_5555, 32'h6666_6666);
    tick();
    tick();
    RESETn = 1'b0;
    tick();
    check_reset_outputs("midreset");
    RESETn = 1'b1;
    tick();
    check("midreset_stays_idle", 32'(HREADYOUT), 32'd1);

`ifdef HOST_SLAVE_TIMEOUT_EN
    // no reply: ERROR after TMO cycles in RX_STAT, no RX pops; late byte stays queued
    clear_env();
    start(1'b0, 3'd2, 32'h4000_0040, 32'h0);
    wait_done(waits, resp, rd, resp_low);
    check("tmo_resp", 32'(resp), 32'd1);
    check("tmo_rdata", rd, ERR_RDATA);
    check("tmo_wait_cycles", 32'(waits), 32'(1 + 4 + TMO + 1));
    check("tmo_err1_cycles", 32'(resp_low), 32'd1);
    tick();
    rx_q.push_back(8'h00);
    RDEMPTY = 1'b0;
    tick();
    tick();
    check("tmo_pops", 32'(pops), 32'd0);
    check("tmo_late_byte_kept", 32'(rx_q.size()), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_host_slave.md
Name: ahb3lite_host_slave

Overview:
- AHB3-lite slave that forwards each bus transfer as a byte-serial request frame to the host, through the TX byte FIFO.
- Waits for the host's response frame on the RX byte FIFO, then completes the AHB data phase with that response.
- Mirror of the host master bridge: lets an address window be emulated by host software over the same UART transport.
- Sits on an interconnect slave port; the FIFO side connects to the dual-clock FIFOs feeding the UART transport.

Parameters:
- ERR_RDATA, 32'hDEAD_BEEF, HRDATA value driven on an ERROR response.
- TIMEOUT_CYCLES, 65535, cycles to wait for the response status byte (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RESETn  in  1  synchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HWRITE  in  1  write transfer
- HSIZE  in  3  transfer size
- HBURST  in  3  ignored
- HPROT  in  4  ignored
- HTRANS  in  2  transfer type
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- WREN  out  1  push WRDATA into the TX FIFO
- WRFULL  in  1  TX FIFO full
- WRDATA  out  8  TX byte
- RDEN  out  1  pop from the RX FIFO
- RDEMPTY  in  1  RX FIFO empty
- RDDATA  in  8  RX byte, valid in the cycle after an accepted RDEN

Behaviour:
- Clock and reset (already decided): single clock CLK; RESETn is synchronous and active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, WREN=0, RDEN=0, WRDATA=0, state=IDLE. Reset asserted mid-frame aborts the frame, with no flush of the FIFOs.
- Address-phase accept: HSEL & HREADY & HTRANS[1] in IDLE. Latch HADDR, HWRITE and HSIZE; drive HREADYOUT=0 from the next cycle.
- IDLE/BUSY transfers, or HSEL low: OKAY with zero wait states.
- Request command byte: {HWRITE, HSIZE[2:0], 4'h0}.
- Request frame: cmd, then address MSB first (4 bytes), then for writes HWDATA MSB first (4 bytes). Frame length is 5 bytes for a read, 9 for a write.
- HWDATA is captured in the first data-phase cycle (state TX_CMD) and held in a register.
- WREN is asserted only when WRFULL=0; one byte per accepted cycle. While WRFULL=1, WREN=0 and the state holds.
- Response frame: status byte; for reads only, 4 data bytes MSB first follow, and only when status=0x00.
- RDEN is asserted only when RDEMPTY=0; RDDATA is sampled the following cycle. At most one RDEN is outstanding, so throughput is one byte per 2 cycles.
- States: IDLE -> TX_CMD -> TX_ADDR(3..0) -> [write: TX_DATA(3..0)] -> RX_STAT.
- From RX_STAT:
  - status==0 and write -> DONE.
  - status==0 and read -> RX_DATA(3..0) -> DONE.
  - status!=0 -> ERR1.
- DONE: HREADYOUT=1, HRESP=0 for one cycle; HRDATA holds the assembled word; return to IDLE. A new accept in the DONE cycle is honoured (pipelined): go straight to TX_CMD.
- Error response: ERR1 drives HRESP=1, HREADYOUT=0; ERR2 drives HRESP=1, HREADYOUT=1 and HRDATA=ERR_RDATA; then IDLE. A new address phase during ERR2 is ignored.
- Transfer-to-transfer latency, empty FIFOs: a read with the response already queued completes in ≥ 1+5+10 cycles.

Optional Feature:
- Macro: HOST_SLAVE_TIMEOUT_EN.
- Defined: a 32-bit counter clears on entry to RX_STAT and increments each cycle while RDEMPTY=1 in RX_STAT. On reaching TIMEOUT_CYCLES, go to ERR1; no RX bytes are consumed. A late status byte remains in the FIFO for software to resynchronise.
- Undefined: RX_STAT waits indefinitely; no counter logic is synthesised.

Test Plan:
- Read 0x4000_0010, HSIZE=2, host replies 00 12 34 56 78 -> TX bytes 20 40 00 00 10; HRDATA=0x12345678, HRESP=0, single HREADYOUT rising.
- Write 0x4000_0004 data 0xCAFEF00D, HSIZE=0, reply 00 -> TX bytes 80 40 00 00 04 CA FE F0 0D; OKAY.
- Read with reply 01 -> two-cycle ERROR (HRESP=1 with HREADYOUT 0 then 1); HRDATA=0xDEADBEEF; no further RX pops.
- WRFULL held high 20 cycles mid-address -> WREN=0 throughout the stall; frame resumes with no byte lost or duplicated.
- Back-to-back reads, second address phase in the DONE cycle -> second frame starts next cycle. IDLE transfer -> zero-wait OKAY.
- With HOST_SLAVE_TIMEOUT_EN and TIMEOUT_CYCLES=16, no reply -> ERROR after 16 cycles in RX_STAT; RESETn low mid-frame -> all outputs return to reset values next edge.
